li_ram_arbiter: RTL and testbench
=================================

Name: li_ram_arbiter

Overview:
Shares one li_ram instance between NUM_CLIENTS independent requesters. Read-request and write channels are each arbitrated round-robin. Read responses from the RAM return in issue order and are routed back to the issuing client through an in-order tag FIFO. The block sits between client engines (loaders, readout sequencers) and a single li_ram, so that several units can use one RAM without a separate RAM per unit.

Parameters:
NUM_CLIENTS, 2, number of requesters (2..8)
ADDR_WIDTH, 8, RAM address width (matches li_ram)
DATA_WIDTH, 32, RAM data width (matches li_ram)
MAX_OUTSTANDING, 4, tag FIFO depth = max reads in flight (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
c_rd_req_addr_in  in  NUM_CLIENTS*ADDR_WIDTH  per-client read address, client i at slice i
c_rd_req_valid_in  in  NUM_CLIENTS  per-client read request valid
c_rd_req_ready_out  out  NUM_CLIENTS  per-client read request accepted
c_rd_resp_data_out  out  DATA_WIDTH  read data, broadcast to all clients
c_rd_resp_valid_out  out  NUM_CLIENTS  one-hot response valid
c_rd_resp_ready_in  in  NUM_CLIENTS  per-client response ready
c_wr_addr_in  in  NUM_CLIENTS*ADDR_WIDTH  per-client write address
c_wr_data_in  in  NUM_CLIENTS*DATA_WIDTH  per-client write data
c_wr_valid_in  in  NUM_CLIENTS  per-client write valid
c_wr_ready_out  out  NUM_CLIENTS  per-client write accepted
ram_rd_req_addr_out  out  ADDR_WIDTH  to li_ram rd_req_addr_in
ram_rd_req_valid_out  out  1  to li_ram rd_req_valid_in
ram_rd_req_ready_in  in  1  from li_ram rd_req_ready_out
ram_rd_resp_data_in  in  DATA_WIDTH  from li_ram rd_resp_data_out
ram_rd_resp_valid_in  in  1  from li_ram rd_resp_valid_out
ram_rd_resp_ready_out  out  1  to li_ram rd_resp_ready_in
ram_wr_addr_out  out  ADDR_WIDTH  to li_ram wr_addr_in
ram_wr_data_out  out  DATA_WIDTH  to li_ram wr_data_in
ram_wr_valid_out  out  1  to li_ram wr_valid_in
ram_wr_ready_in  in  1  from li_ram wr_ready_out
outstanding_out  out  $clog2(MAX_OUTSTANDING)+1  reads in flight
err_orphan_resp_out  out  1  sticky: RAM response arrived with no tag outstanding

Behaviour:
- Reset (rst high at posedge): both round-robin pointers are set to NUM_CLIENTS-1, so client 0 has highest priority first. Tag FIFO is emptied, outstanding_out=0, err_orphan_resp_out=0.
- Read grant (combinational): the rotating-priority pick among c_rd_req_valid_in, starting at rd_ptr+1 mod NUM_CLIENTS.
- ram_rd_req_valid_out = |c_rd_req_valid_in & !tag_full. ram_rd_req_addr_out = the granted client's slice (0 when nothing is granted).
- c_rd_req_ready_out[g] = ram_rd_req_ready_in & !tag_full for the granted client only. All other bits are 0.
- Read accept (valid & ready at posedge): push g into the tag FIFO and set rd_ptr<=g. No accept leaves the pointer unchanged, so a stalled grant is held.
- Zero-cycle arbiter latency: a request sees the RAM in the same cycle. Overall read latency = li_ram latency; the arbiter adds no registers in the data path.
- Response routing, tag FIFO non-empty, head h:
  - c_rd_resp_valid_out = ram_rd_resp_valid_in << h.
  - ram_rd_resp_ready_out = c_rd_resp_ready_in[h].
  - c_rd_resp_data_out = ram_rd_resp_data_in.
  - Pop on ram valid & ready.
- Response routing, tag FIFO empty:
  - ram_rd_resp_ready_out=1 and c_rd_resp_valid_out=0; the data is dropped.
  - If ram_rd_resp_valid_in=1, err_orphan_resp_out<=1 and stays set until rst.
- Tag FIFO full (MAX_OUTSTANDING entries): all read readies are 0, even if a pop occurs in the same cycle. Push is gated on the registered full flag only.
- Simultaneous push and pop when not full: occupancy is unchanged and outstanding_out is stable.
- Write channel: independent round-robin with wr_ptr, same rules.
  - ram_wr_valid_out = |c_wr_valid_in.
  - c_wr_ready_out[g] = ram_wr_ready_in.
  - Address and data are muxed from the granted client.
  - wr_ptr<=g on accept.
- Read and write arbitration are independent. A read and a write to the same address in the same cycle are both forwarded; ordering semantics are li_ram's.
- Client backpressure on responses stalls the RAM response channel and therefore other clients' responses. This is documented behaviour; no reordering.
- rst mid-operation: in-flight tags are discarded. RAM responses arriving after reset flag err_orphan_resp_out. li_ram is expected to share rst.
- FIFO pointers are $clog2(MAX_OUTSTANDING) bits and wrap naturally. Count is one bit wider.

Decomposition:
- Package li_ram_arb_pkg: localparam TAG_W=$clog2(NUM_CLIENTS), typedef client_id_t logic[TAG_W-1:0], and a function rr_pick(req, ptr) returning a one-hot grant.
- Sub-module rr_arbiter (req, ptr, accept -> grant, grant_id, ptr update), instantiated twice (read, write).
- The tag FIFO is inline in the top.

Test Plan:
- Reset, then client 0 alone reads 0x05, 0x06 (RAM preloaded with 1000+addr) -> client 0 receives 1005, 1006 in order; c_rd_resp_valid_out[1] never asserts.
- Both clients request every cycle (client 0 at 0x10 upward, client 1 at 0x80 upward) -> grants alternate 0,1,0,1; each client receives only its own data (1016, 1128, ...).
- Client 1 holds c_rd_resp_ready_in=0 with 4 reads outstanding -> outstanding_out=4, all c_rd_req_ready_out=0; release -> drains in issue order, then requests resume.
- Both clients write the same cycle (client 0: 0x20<=0xAAAA, client 1: 0x21<=0xBBBB) -> serialized in 2 cycles, client 0 first; readback returns 0xAAAA, 0xBBBB.
- Inject a RAM response with the FIFO empty -> err_orphan_resp_out=1 next cycle, no client valid; stays set until rst.
- Assert rst with 3 reads outstanding -> outstanding_out=0, pointers reset, next dual request is granted to client 0.

Source files
------------

// File: rtl/li_ram_arbiter_pkg.sv
// li_ram_arbiter shared types and helpers.
// Round-robin pick used by both arbiters.
package li_ram_arb_pkg;

  localparam int MAX_CLIENTS = 8;
  localparam int TAG_W = $clog2(MAX_CLIENTS);

  typedef logic [TAG_W-1:0] client_id_t;

  function automatic logic [MAX_CLIENTS-1:0] rr_pick(
    input logic [MAX_CLIENTS-1:0] req,
    input client_id_t             ptr,
    input int                     n
  );
    logic [MAX_CLIENTS-1:0] g;
    logic                   found;
    int                     idx;
    g     = '0;
    found = 1'b0;
    for (int k = 1; k <= MAX_CLIENTS; k++) begin
      idx = int'(ptr) + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !found && req[idx]) begin
        g[idx] = 1'b1;
        found  = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/li_ram_arbiter_if.sv
// Request/response/write bundle, N lanes wide.
// Clients use N=NUM_CLIENTS, the RAM side N=1.
interface li_ram_arbiter_if #(
  parameter int N  = 2,
  parameter int AW = 8,
  parameter int DW = 32
);

  logic [N*AW-1:0] rd_req_addr;
  logic [N-1:0]    rd_req_valid;
  logic [N-1:0]    rd_req_ready;
  logic [DW-1:0]   rd_resp_data;
  logic [N-1:0]    rd_resp_valid;
  logic [N-1:0]    rd_resp_ready;
  logic [N*AW-1:0] wr_addr;
  logic [N*DW-1:0] wr_data;
  logic [N-1:0]    wr_valid;
  logic [N-1:0]    wr_ready;

  modport master (
    output rd_req_addr, rd_req_valid,
    output rd_resp_ready,
    output wr_addr, wr_data, wr_valid,
    input  rd_req_ready,
    input  rd_resp_data, rd_resp_valid,
    input  wr_ready
  );

  modport slave (
    input  rd_req_addr, rd_req_valid,
    input  rd_resp_ready,
    input  wr_addr, wr_data, wr_valid,
    output rd_req_ready,
    output rd_resp_data, rd_resp_valid,
    output wr_ready
  );

endinterface

// File: rtl/li_ram_arbiter_rr_arbiter.sv
// Rotating-priority arbiter with held pointer.
// Pointer moves to the grantee only on accept.
module rr_arbiter
  import li_ram_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [N-1:0] i_req,
  input  logic       i_accept,
  output logic [N-1:0] o_grant,
  output client_id_t o_grant_id
);

  client_id_t             r_ptr;
  logic [MAX_CLIENTS-1:0] w_pick;

  assign w_pick  = rr_pick(MAX_CLIENTS'(i_req), r_ptr, N);
  assign o_grant = w_pick[N-1:0];

  // one-hot grant to client index
  always_comb begin
    o_grant_id = '0;
    for (int i = 0; i < N; i++)
      if (o_grant[i]) o_grant_id = client_id_t'(i);
  end

  // last-served pointer, client 0 first out of reset
  always_ff @(posedge clk) begin
    if (rst)
      r_ptr <= client_id_t'(N - 1);
    else if (i_accept)
      r_ptr <= o_grant_id;
  end

endmodule

// File: rtl/li_ram_arbiter.sv
// Shares one li_ram between several clients.
// Read tags return responses in issue order.
module li_ram_arbiter
  import li_ram_arb_pkg::*;
#(
  parameter int NUM_CLIENTS     = 2,
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic clk,
  input  logic rst,
  li_ram_arbiter_if.slave  c,
  li_ram_arbiter_if.master ram,
  output logic [$clog2(MAX_OUTSTANDING):0] outstanding_out,
  output logic err_orphan_resp_out
);

  localparam int N  = NUM_CLIENTS;
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam logic [PW:0] FULL_CNT =
    (PW+1)'(MAX_OUTSTANDING);

  logic [N-1:0] w_rd_grant;
  logic [N-1:0] w_wr_grant;
  client_id_t   w_rd_gid;
  client_id_t   w_wr_gid;
  logic         w_unused;
  logic         w_full;
  logic         w_empty;
  logic         w_rd_any;
  logic         w_rd_acc;
  logic         w_wr_any;
  logic         w_wr_acc;
  logic         w_pop;
  client_id_t   w_head;

  client_id_t   r_tag [MAX_OUTSTANDING];
  logic [PW-1:0] r_wp;
  logic [PW-1:0] r_rp;
  logic [PW:0]   r_cnt;
  logic          r_err;

  assign w_unused = ^w_wr_gid;
  assign w_full   = (r_cnt == FULL_CNT);
  assign w_empty  = (r_cnt == '0);
  assign w_head   = r_tag[r_rp];

  assign w_rd_any = |c.rd_req_valid;
  assign w_rd_acc = w_rd_any & ~w_full
                  & ram.rd_req_ready[0];
  assign w_wr_any = |c.wr_valid;
  assign w_wr_acc = w_wr_any & ram.wr_ready[0];

  rr_arbiter #(.N(N)) u_rd_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (c.rd_req_valid),
    .i_accept   (w_rd_acc),
    .o_grant    (w_rd_grant),
    .o_grant_id (w_rd_gid)
  );

  rr_arbiter #(.N(N)) u_wr_arb (
    .clk        (clk),
    .rst        (rst),
    .i_req      (c.wr_valid),
    .i_accept   (w_wr_acc),
    .o_grant    (w_wr_grant),
    .o_grant_id (w_wr_gid)
  );

  assign ram.rd_req_valid = w_rd_any & ~w_full;
  assign c.rd_req_ready   = w_rd_grant
    & {N{ram.rd_req_ready[0] & ~w_full}};

  // granted read address, zero when idle
  always_comb begin
    ram.rd_req_addr = '0;
    for (int i = 0; i < N; i++)
      if (w_rd_grant[i])
        ram.rd_req_addr =
          c.rd_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
  end

  assign ram.wr_valid = w_wr_any;
  assign c.wr_ready   = w_wr_grant
    & {N{ram.wr_ready[0]}};

  // granted write address and data
  always_comb begin
    ram.wr_addr = '0;
    ram.wr_data = '0;
    for (int i = 0; i < N; i++)
      if (w_wr_grant[i]) begin
        ram.wr_addr =
          c.wr_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        ram.wr_data =
          c.wr_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  assign c.rd_resp_data = ram.rd_resp_data;

  // route the head response; drain orphans
  always_comb begin
    c.rd_resp_valid   = '0;
    ram.rd_resp_ready = 1'b1;
    if (!w_empty) begin
      ram.rd_resp_ready = 1'b0;
      for (int i = 0; i < N; i++)
        if (w_head == client_id_t'(i)) begin
          c.rd_resp_valid[i] = ram.rd_resp_valid[0];
          ram.rd_resp_ready  = c.rd_resp_ready[i];
        end
    end
  end

  assign w_pop = ~w_empty & ram.rd_resp_valid[0]
               & c.rd_resp_ready[w_head];

  // tag storage, contents need no reset
  always_ff @(posedge clk) begin
    if (w_rd_acc) r_tag[r_wp] <= w_rd_gid;
  end

  // tag FIFO pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_rd_acc) r_wp <= r_wp + 1'b1;
      if (w_pop)    r_rp <= r_rp + 1'b1;
      if (w_rd_acc && !w_pop)
        r_cnt <= r_cnt + 1'b1;
      else if (!w_rd_acc && w_pop)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  // sticky flag: response with no tag waiting
  always_ff @(posedge clk) begin
    if (rst)
      r_err <= 1'b0;
    else if (w_empty && ram.rd_resp_valid[0])
      r_err <= 1'b1;
  end

  assign outstanding_out     = r_cnt;
  assign err_orphan_resp_out = r_err;

endmodule

// File: tb/tb_li_ram_arbiter.sv
// Directed bench for li_ram_arbiter.
// Behavioural li_ram: 1-cycle read latency.
module tb_li_ram_arbiter;

  logic clk = 1'b0;
  logic rst;
  logic [2:0] outst;
  logic err;

  always #5 clk = ~clk;

  li_ram_arbiter_if #(.N(2), .AW(8), .DW(32)) cif ();
  li_ram_arbiter_if #(.N(1), .AW(8), .DW(32)) rif ();

  li_ram_arbiter #(
    .NUM_CLIENTS     (2),
    .ADDR_WIDTH      (8),
    .DATA_WIDTH      (32),
    .MAX_OUTSTANDING (4)
  ) dut (
    .clk                 (clk),
    .rst                 (rst),
    .c                   (cif),
    .ram                 (rif),
    .outstanding_out     (outst),
    .err_orphan_resp_out (err)
  );

  // RAM model
  logic [31:0] mem [256];
  logic [31:0] mq [16];
  int mh = 0;
  int mt = 0;
  logic inj;
  logic [31:0] inj_data;

  assign rif.rd_req_ready  = 1'b1;
  assign rif.wr_ready      = 1'b1;
  assign rif.rd_resp_valid = (mt != mh) || inj;
  assign rif.rd_resp_data  = inj ? inj_data : mq[mh % 16];

  always @(posedge clk) begin
    if (rst) begin
      mh <= 0;
      mt <= 0;
      if (mt == 0 && mh == 0)
        for (int i = 0; i < 256; i++)
          mem[i] <= 32'(1000 + i);
    end else begin
      if (rif.rd_resp_valid[0] && rif.rd_resp_ready[0]
          && !inj && mt != mh)
        mh <= mh + 1;
      if (rif.rd_req_valid[0] && rif.rd_req_ready[0]) begin
        mq[mt % 16] <= mem[rif.rd_req_addr];
        mt <= mt + 1;
      end
      if (rif.wr_valid[0] && rif.wr_ready[0])
        mem[rif.wr_addr] <= rif.wr_data;
    end
  end

  // response / grant monitor
  logic [31:0] rx0 [64];
  logic [31:0] rx1 [64];
  int glog [64];
  int nrx0 = 0;
  int nrx1 = 0;
  int ng = 0;
  int v1cnt = 0;

  always @(posedge clk) begin
    if (!rst) begin
      if (cif.rd_resp_valid[0] && cif.rd_resp_ready[0]) begin
        rx0[nrx0 % 64] <= cif.rd_resp_data;
        nrx0 <= nrx0 + 1;
      end
      if (cif.rd_resp_valid[1] && cif.rd_resp_ready[1]) begin
        rx1[nrx1 % 64] <= cif.rd_resp_data;
        nrx1 <= nrx1 + 1;
      end
      if (cif.rd_resp_valid[1]) v1cnt <= v1cnt + 1;
      if (cif.rd_req_valid[0] && cif.rd_req_ready[0]) begin
        glog[ng % 64] <= 0;
        ng <= ng + 1;
      end else if (cif.rd_req_valid[1] && cif.rd_req_ready[1]) begin
        glog[ng % 64] <= 1;
        ng <= ng + 1;
      end
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    inj = 1'b0;
    inj_data = '0;
    cif.rd_req_valid  = '0;
    cif.rd_req_addr   = '0;
    cif.rd_resp_ready = 2'b11;
    cif.wr_valid      = '0;
    cif.wr_addr       = '0;
    cif.wr_data       = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (outst !== 3'd0) begin
      errors++;
      $display("FAIL rst_outst got %0d exp 0", outst);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL rst_err got %b exp 0", err);
    end
    checks++;
    if (cif.rd_req_ready !== 2'b00) begin
      errors++;
      $display("FAIL rst_rdy got %b exp 00", cif.rd_req_ready);
    end
    checks++;
    if (rif.rd_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_rresp_rdy got %b exp 1", rif.rd_resp_ready);
    end
    cif.rd_req_addr  = {8'h02, 8'h01};
    cif.rd_req_valid = 2'b11;
    #1;
    checks++;
    if (cif.rd_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL rst_prio got %b exp 01", cif.rd_req_ready);
    end
    checks++;
    if (rif.rd_req_addr !== 8'h01) begin
      errors++;
      $display("FAIL rst_addr got %h exp 01", rif.rd_req_addr);
    end
    cif.rd_req_valid = 2'b00;
    #1;
    checks++;
    if (rif.rd_req_valid !== 1'b0 || rif.rd_req_addr !== 8'h00) begin
      errors++;
      $display("FAIL idle_addr got %b/%h exp 0/00",
               rif.rd_req_valid, rif.rd_req_addr);
    end
  endtask

  task automatic test_single_client();
    int b0, b1, bv;
    do_reset();
    b0 = nrx0;
    b1 = nrx1;
    bv = v1cnt;
    cif.rd_req_addr  = {8'h00, 8'h05};
    cif.rd_req_valid = 2'b01;
    step();
    cif.rd_req_addr  = {8'h00, 8'h06};
    step();
    cif.rd_req_valid = 2'b00;
    for (int k = 0; k < 20 && nrx0 < b0 + 2; k++) step();
    checks++;
    if (nrx0 !== b0 + 2) begin
      errors++;
      $display("FAIL single_cnt got %0d exp %0d", nrx0 - b0, 2);
    end
    checks++;
    if (rx0[b0 % 64] !== 32'd1005) begin
      errors++;
      $display("FAIL single_d0 got %0d exp 1005", rx0[b0 % 64]);
    end
    checks++;
    if (rx0[(b0 + 1) % 64] !== 32'd1006) begin
      errors++;
      $display("FAIL single_d1 got %0d exp 1006", rx0[(b0 + 1) % 64]);
    end
    checks++;
    if (v1cnt !== bv || nrx1 !== b1) begin
      errors++;
      $display("FAIL single_c1 got %0d exp 0", v1cnt - bv);
    end
    checks++;
    if (outst !== 3'd0) begin
      errors++;
      $display("FAIL single_outst got %0d exp 0", outst);
    end
  endtask

  task automatic test_alternate();
    int b0, b1, bg, n0, n1;
    logic [1:0] g;
    int exp_g [4];
    logic [31:0] e0 [2];
    logic [31:0] e1 [2];
    exp_g = '{0, 1, 0, 1};
    e0 = '{32'd1016, 32'd1017};
    e1 = '{32'd1128, 32'd1129};
    do_reset();
    b0 = nrx0;
    b1 = nrx1;
    bg = ng;
    n0 = 0;
    n1 = 0;
    for (int k = 0; k < 4; k++) begin
      cif.rd_req_addr = {8'(8'h80 + n1), 8'(8'h10 + n0)};
      cif.rd_req_valid = 2'b11;
      #1;
      g = cif.rd_req_ready;
      step();
      if (g[0]) n0++;
      if (g[1]) n1++;
    end
    cif.rd_req_valid = 2'b00;
    for (int k = 0; k < 20 && (nrx0 < b0 + 2 || nrx1 < b1 + 2); k++)
      step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (glog[(bg + k) % 64] !== exp_g[k]) begin
        errors++;
        $display("FAIL alt_grant%0d got %0d exp %0d",
                 k, glog[(bg + k) % 64], exp_g[k]);
      end
    end
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (rx0[(b0 + k) % 64] !== e0[k]) begin
        errors++;
        $display("FAIL alt_c0_d%0d got %0d exp %0d",
                 k, rx0[(b0 + k) % 64], e0[k]);
      end
      checks++;
      if (rx1[(b1 + k) % 64] !== e1[k]) begin
        errors++;
        $display("FAIL alt_c1_d%0d got %0d exp %0d",
                 k, rx1[(b1 + k) % 64], e1[k]);
      end
    end
    checks++;
    if (nrx0 !== b0 + 2 || nrx1 !== b1 + 2) begin
      errors++;
      $display("FAIL alt_cnt got %0d/%0d exp 2/2", nrx0 - b0, nrx1 - b1);
    end
  endtask

  task automatic test_backpressure();
    int b0, b1;
    do_reset();
    b0 = nrx0;
    b1 = nrx1;
    cif.rd_resp_ready = 2'b01;
    for (int k = 0; k < 4; k++) begin
      cif.rd_req_addr  = {8'(8'h30 + k), 8'h00};
      cif.rd_req_valid = 2'b10;
      #1;
      checks++;
      if (cif.rd_req_ready !== 2'b10) begin
        errors++;
        $display("FAIL bp_accept%0d got %b exp 10", k, cif.rd_req_ready);
      end
      step();
    end
    cif.rd_req_addr  = {8'h34, 8'h40};
    cif.rd_req_valid = 2'b11;
    #1;
    checks++;
    if (outst !== 3'd4) begin
      errors++;
      $display("FAIL bp_outst got %0d exp 4", outst);
    end
    checks++;
    if (cif.rd_req_ready !== 2'b00 || rif.rd_req_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_full_rdy got %b/%b exp 00/0",
               cif.rd_req_ready, rif.rd_req_valid);
    end
    checks++;
    if (cif.rd_resp_valid !== 2'b10 || rif.rd_resp_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_stall got %b/%b exp 10/0",
               cif.rd_resp_valid, rif.rd_resp_ready);
    end
    step();
    checks++;
    if (outst !== 3'd4 || nrx1 !== b1) begin
      errors++;
      $display("FAIL bp_hold got %0d/%0d exp 4/0", outst, nrx1 - b1);
    end
    cif.rd_req_valid  = 2'b00;
    cif.rd_resp_ready = 2'b11;
    for (int k = 0; k < 20 && nrx1 < b1 + 4; k++) step();
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (rx1[(b1 + k) % 64] !== 32'(1048 + k)) begin
        errors++;
        $display("FAIL bp_drain%0d got %0d exp %0d",
                 k, rx1[(b1 + k) % 64], 1048 + k);
      end
    end
    checks++;
    if (outst !== 3'd0 || nrx0 !== b0) begin
      errors++;
      $display("FAIL bp_empty got %0d/%0d exp 0/0", outst, nrx0 - b0);
    end
    cif.rd_req_addr  = {8'h00, 8'h40};
    cif.rd_req_valid = 2'b01;
    #1;
    checks++;
    if (cif.rd_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL bp_resume got %b exp 01", cif.rd_req_ready);
    end
    step();
    cif.rd_req_valid = 2'b00;
    for (int k = 0; k < 20 && nrx0 < b0 + 1; k++) step();
    checks++;
    if (rx0[b0 % 64] !== 32'd1064) begin
      errors++;
      $display("FAIL bp_resume_d got %0d exp 1064", rx0[b0 % 64]);
    end
  endtask

  task automatic test_write();
    int b0;
    do_reset();
    b0 = nrx0;
    cif.wr_addr  = {8'h21, 8'h20};
    cif.wr_data  = {32'h0000BBBB, 32'h0000AAAA};
    cif.wr_valid = 2'b11;
    #1;
    checks++;
    if (cif.wr_ready !== 2'b01 || rif.wr_valid !== 1'b1) begin
      errors++;
      $display("FAIL wr_first got %b/%b exp 01/1",
               cif.wr_ready, rif.wr_valid);
    end
    checks++;
    if (rif.wr_addr !== 8'h20 || rif.wr_data !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL wr_first_bus got %h/%h exp 20/0000aaaa",
               rif.wr_addr, rif.wr_data);
    end
    step();
    cif.wr_valid = 2'b10;
    #1;
    checks++;
    if (cif.wr_ready !== 2'b10) begin
      errors++;
      $display("FAIL wr_second got %b exp 10", cif.wr_ready);
    end
    checks++;
    if (rif.wr_addr !== 8'h21 || rif.wr_data !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL wr_second_bus got %h/%h exp 21/0000bbbb",
               rif.wr_addr, rif.wr_data);
    end
    step();
    cif.wr_valid = 2'b00;
    cif.rd_req_addr  = {8'h00, 8'h20};
    cif.rd_req_valid = 2'b01;
    step();
    cif.rd_req_addr  = {8'h00, 8'h21};
    step();
    cif.rd_req_valid = 2'b00;
    for (int k = 0; k < 20 && nrx0 < b0 + 2; k++) step();
    checks++;
    if (rx0[b0 % 64] !== 32'h0000AAAA) begin
      errors++;
      $display("FAIL wr_rb0 got %h exp 0000aaaa", rx0[b0 % 64]);
    end
    checks++;
    if (rx0[(b0 + 1) % 64] !== 32'h0000BBBB) begin
      errors++;
      $display("FAIL wr_rb1 got %h exp 0000bbbb", rx0[(b0 + 1) % 64]);
    end
  endtask

  task automatic test_orphan();
    do_reset();
    inj_data = 32'h0000DEAD;
    inj = 1'b1;
    #1;
    checks++;
    if (cif.rd_resp_valid !== 2'b00 || rif.rd_resp_ready !== 1'b1) begin
      errors++;
      $display("FAIL orph_route got %b/%b exp 00/1",
               cif.rd_resp_valid, rif.rd_resp_ready);
    end
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL orph_early got %b exp 0", err);
    end
    step();
    inj = 1'b0;
    #1;
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL orph_set got %b exp 1", err);
    end
    step();
    step();
    step();
    checks++;
    if (err !== 1'b1 || outst !== 3'd0) begin
      errors++;
      $display("FAIL orph_sticky got %b/%0d exp 1/0", err, outst);
    end
  endtask

  task automatic test_reset_mid();
    cif.rd_resp_ready = 2'b00;
    for (int k = 0; k < 3; k++) begin
      cif.rd_req_addr  = {8'h00, 8'(8'h50 + k)};
      cif.rd_req_valid = 2'b01;
      step();
    end
    cif.rd_req_valid = 2'b00;
    #1;
    checks++;
    if (outst !== 3'd3 || err !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre got %0d/%b exp 3/1", outst, err);
    end
    rst = 1'b1;
    step();
    rst = 1'b0;
    cif.rd_resp_ready = 2'b11;
    #1;
    checks++;
    if (outst !== 3'd0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_clear got %0d/%b exp 0/0", outst, err);
    end
    checks++;
    if (cif.rd_resp_valid !== 2'b00) begin
      errors++;
      $display("FAIL mid_resp got %b exp 00", cif.rd_resp_valid);
    end
    cif.rd_req_addr  = {8'h81, 8'h11};
    cif.rd_req_valid = 2'b11;
    #1;
    checks++;
    if (cif.rd_req_ready !== 2'b01) begin
      errors++;
      $display("FAIL mid_prio got %b exp 01", cif.rd_req_ready);
    end
    cif.rd_req_valid = 2'b00;
  endtask

  initial begin
    rst = 1'b1;
    inj = 1'b0;
    inj_data = '0;
    cif.rd_req_valid  = '0;
    cif.rd_req_addr   = '0;
    cif.rd_resp_ready = 2'b11;
    cif.wr_valid      = '0;
    cif.wr_addr       = '0;
    cif.wr_data       = '0;
    test_reset();
    test_single_client();
    test_alternate();
    test_backpressure();
    test_write();
    test_orphan();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
